// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, word-addressed data memory, branch resolve, MEM/WB register.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int unsigned DMEM_ADDR_W = 8,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] pc_branch,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [4:0]        write_reg,
    output logic              pcsrc,
    output logic [DATA_W-1:0] pc_branch_out,
    output logic [DATA_W-1:0] read_data_wb,
    output logic [DATA_W-1:0] alu_res_wb,
    output logic [4:0]        write_reg_wb,
    output logic              reg_write_wb,
    output logic              mem_to_reg_wb,
    output logic              misalign_err
);

    localparam int unsigned DEPTH = 1 << DMEM_ADDR_W;
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic              zero;
        logic [DATA_W-1:0] pc_branch;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] rt_data;
        logic [REG_W-1:0]  write_reg;
    } exmem_t;

    exmem_t exmem_d;
    exmem_t exmem_q;

    logic [DMEM_ADDR_W-1:0] word_idx_c;
    logic [DATA_W-1:0]      read_data_c;
    logic                   misaligned_c;
    logic                   we_c;

    logic [DATA_W-1:0] dmem [DEPTH];

    // Pack the execute-stage outputs into the EX/MEM payload
    always_comb begin
        exmem_d            = '0;
        exmem_d.branch     = branch;
        exmem_d.mem_read   = mem_read;
        exmem_d.mem_write  = mem_write;
        exmem_d.reg_write  = reg_write;
        exmem_d.mem_to_reg = mem_to_reg;
        exmem_d.zero       = alu_zero;
        exmem_d.pc_branch  = pc_branch;
        exmem_d.alu_res    = alu_res;
        exmem_d.rt_data    = rt_data;
        exmem_d.write_reg  = write_reg;
    end

    // EX/MEM register: a flush inserts a bubble even while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
        end else if (flush) begin
            exmem_q <= '0;
        end else if (!stall) begin
            exmem_q <= exmem_d;
        end
    end

    assign word_idx_c = exmem_q.alu_res[DMEM_ADDR_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned_c = (exmem_q.mem_read | exmem_q.mem_write) & (exmem_q.alu_res[1:0] != 2'b00);
`else
    assign misaligned_c = 1'b0;
`endif

    assign we_c        = exmem_q.mem_write & ~stall & ~misaligned_c;
    assign read_data_c = (exmem_q.mem_read & ~misaligned_c) ? dmem[word_idx_c] : '0;

    // Data array is intentionally not reset; contents survive rst_n
    always_ff @(posedge clk) begin
        if (we_c) begin
            dmem[word_idx_c] <= exmem_q.rt_data;
        end
    end

    assign pcsrc         = exmem_q.branch & exmem_q.zero;
    assign pc_branch_out = exmem_q.pc_branch;

    // MEM/WB register; unaffected by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_wb  <= '0;
            alu_res_wb    <= '0;
            write_reg_wb  <= '0;
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
        end else if (!stall) begin
            read_data_wb  <= read_data_c;
            alu_res_wb    <= exmem_q.alu_res;
            write_reg_wb  <= exmem_q.write_reg;
            reg_write_wb  <= exmem_q.reg_write;
            mem_to_reg_wb <= exmem_q.mem_to_reg;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (misaligned_c && !stall) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model compared every cycle plus literal checks.
module tb_mem_stage;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        branch = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_res = '0;
    logic [31:0] rt_data = '0;
    logic [4:0]  write_reg = '0;
    logic        pcsrc;
    logic [31:0] pc_branch_out, read_data_wb, alu_res_wb;
    logic [4:0]  write_reg_wb;
    logic        reg_write_wb, mem_to_reg_wb, misalign_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.DMEM_ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_branch(pc_branch),
        .alu_zero(alu_zero), .alu_res(alu_res), .rt_data(rt_data), .write_reg(write_reg),
        .pcsrc(pcsrc), .pc_branch_out(pc_branch_out), .read_data_wb(read_data_wb),
        .alu_res_wb(alu_res_wb), .write_reg_wb(write_reg_wb), .reg_write_wb(reg_write_wb),
        .mem_to_reg_wb(mem_to_reg_wb), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction currently occupying the memory stage, as the model sees it
    typedef struct {
        bit          br, rd, wr, rw, m2r, zero;
        logic [31:0] pcb, alu, rt;
        logic [4:0]  wreg;
    } instr_t;

    instr_t      m_ex = '{default: '0};
    logic [31:0] e_rd = '0, e_alu = '0;
    logic [4:0]  e_wreg = '0;
    bit          e_rw = 1'b0, e_m2r = 1'b0, e_rd_known = 1'b1, e_err = 1'b0;
    logic [31:0] mmem [int];

    function automatic bit misal(input instr_t i);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (i.rd || i.wr) && ((i.alu % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Model: effect of each clock edge on the stage, expressed per instruction
    always @(posedge clk or negedge rst_n) begin
        int          idx;
        logic [31:0] rv;
        bit          rk;
        if (!rst_n) begin
            m_ex = '{default: '0};
            e_rd = '0; e_alu = '0; e_wreg = '0;
            e_rw = 1'b0; e_m2r = 1'b0; e_rd_known = 1'b1; e_err = 1'b0;
        end else begin
            if (!stall) begin
                idx = int'((m_ex.alu >> 2) % DEPTH);
                rv  = '0;
                rk  = 1'b1;
                if (m_ex.rd && !misal(m_ex)) begin
                    if (mmem.exists(idx)) rv = mmem[idx];
                    else rk = 1'b0;
                end
                if (m_ex.wr && !misal(m_ex)) mmem[idx] = m_ex.rt;
                if (misal(m_ex)) e_err = 1'b1;
                e_rd = rv; e_rd_known = rk;
                e_alu = m_ex.alu; e_wreg = m_ex.wreg; e_rw = m_ex.rw; e_m2r = m_ex.m2r;
            end
            if (flush) m_ex = '{default: '0};
            else if (!stall)
                m_ex = '{br: branch, rd: mem_read, wr: mem_write, rw: reg_write, m2r: mem_to_reg,
                         zero: alu_zero, pcb: pc_branch, alu: alu_res, rt: rt_data, wreg: write_reg};
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("pcsrc", 32'(pcsrc), 32'(m_ex.br & m_ex.zero));
        chk("pc_branch_out", pc_branch_out, m_ex.pcb);
        if (e_rd_known) chk("read_data_wb", read_data_wb, e_rd);
        chk("alu_res_wb", alu_res_wb, e_alu);
        chk("write_reg_wb", 32'(write_reg_wb), 32'(e_wreg));
        chk("reg_write_wb", 32'(reg_write_wb), 32'(e_rw));
        chk("mem_to_reg_wb", 32'(mem_to_reg_wb), 32'(e_m2r));
        chk("misalign_err", 32'(misalign_err), 32'(e_err));
    end

    task automatic drive(input bit st, input bit fl, input bit br, input bit rd, input bit wr,
                         input bit rw, input bit m2r, input logic [31:0] pcb, input bit z,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wreg);
        stall = st; flush = fl; branch = br; mem_read = rd; mem_write = wr;
        reg_write = rw; mem_to_reg = m2r; pc_branch = pcb; alu_zero = z;
        alu_res = alu; rt_data = rt; write_reg = wreg;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input bit st, input bit fl, input bit rw);
        drive(st, fl, 1'b0, 1'b0, 1'b1, rw, 1'b0, '0, 1'b0, a, d, '0);
    endtask

    task automatic lw(input logic [31:0] a, input logic [4:0] r, input bit st);
        drive(st, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0, 1'b0, a, '0, r);
    endtask

    task automatic rnd_inputs();
        drive(1'(($urandom)), 1'(($urandom)), 1'(($urandom)), 1'(($urandom)), 1'(($urandom)),
              1'(($urandom)), 1'(($urandom)), $urandom, 1'(($urandom)), $urandom, $urandom,
              5'(($urandom)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pcsrc"}, 32'(pcsrc), 32'd0);
        chk({tag, "_pcb"}, pc_branch_out, 32'd0);
        chk({tag, "_rd"}, read_data_wb, 32'd0);
        chk({tag, "_alu"}, alu_res_wb, 32'd0);
        chk({tag, "_ctl"}, 32'({write_reg_wb, reg_write_wb, mem_to_reg_wb, misalign_err}), 32'd0);
    endtask

    initial begin
        // Reset asserted mid-cycle, random inputs while held
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        rnd_inputs();
        rnd_inputs();
        chk_all_zero("rst_hold");
        stall = 1'b0; flush = 1'b0;
        nop();
        rst_n = 1'b1;

        // First result reaches *_wb two edges after presentation
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h1357_2468, '0, 5'd9);
        chk("lat_edge1", alu_res_wb, 32'd0);
        nop();
        chk("lat_edge2", alu_res_wb, 32'h1357_2468);

        // Store then load, plus address wrap
        sw(32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        lw(32'h8, 5'd5, 1'b0);
        nop();
        chk("lw_data", read_data_wb, 32'hDEAD_BEEF);
        chk("lw_reg", 32'(write_reg_wb), 32'd5);
        lw(32'h408, 5'd6, 1'b0);
        nop();
        chk("lw_wrap", read_data_wb, 32'hDEAD_BEEF);

        // Branch resolution
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, '0, '0, '0);
        chk("br_taken", 32'(pcsrc), 32'd1);
        chk("br_target", pc_branch_out, 32'h40);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, '0, '0, '0);
        chk("br_not_taken", 32'(pcsrc), 32'd0);

        // Flushed store must not write; flushed slot carries no reg_write
        sw(32'h10, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        sw(32'h10, 32'h0000_1234, 1'b0, 1'b1, 1'b1);
        nop();
        chk("flush_rw", 32'(reg_write_wb), 32'd0);
        lw(32'h10, 5'd3, 1'b0);
        nop();
        chk("flush_data", read_data_wb, 32'h1111_1111);

        // Store held in EX/MEM across a three-cycle stall
        sw(32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) lw(32'h20, 5'd4, 1'b1);
        lw(32'h20, 5'd4, 1'b0);
        nop();
        chk("stall_data", read_data_wb, 32'hA5A5_A5A5);

        // Misaligned store against word 1
        sw(32'h4, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        sw(32'h6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        lw(32'h4, 5'd7, 1'b0);
        lw(32'h6, 5'd8, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_word1", read_data_wb, 32'h0000_0077);
        nop();
        chk("mis_load", read_data_wb, 32'd0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        sw(32'hC, 32'h5, 1'b0, 1'b0, 1'b0);
        lw(32'hC, 5'd1, 1'b0);
        nop();
        chk("mis_sticky", 32'(misalign_err), 32'd1);
`else
        chk("mis_word1", read_data_wb, 32'hFFFF_FFFF);
        nop();
        chk("mis_load", read_data_wb, 32'hFFFF_FFFF);
        chk("mis_err", 32'(misalign_err), 32'd0);
`endif

        // Reset mid-operation: stores during reset are lost, memory persists
        sw(32'h8, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        sw(32'h8, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        chk_all_zero("rst_mid_hold");
        nop();
        rst_n = 1'b1;
        lw(32'h8, 5'd2, 1'b0);
        nop();
        chk("rst_persist", read_data_wb, 32'hDEAD_BEEF);
        nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined MIPS datapath, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, a word-addressed data memory, branch resolution (PCSrc to fetch) and the MEM/WB pipeline register.
- Consumes execute outputs (alu_res, alu_zero, pc_branch, write_reg) plus store data (rt_data) and MEM/WB control bits.
- Produces write-back operands and the taken-branch redirect.

Parameters:
- DMEM_ADDR_W, 8, word-address width; memory depth = 2**DMEM_ADDR_W 32-bit words.
- DATA_W, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold both pipeline registers; suppress memory write.
- flush  input  1  load a bubble into EX/MEM in place of the EX instruction.
- branch  input  1  EX control: instruction is beq.
- mem_read  input  1  EX control: load.
- mem_write  input  1  EX control: store.
- reg_write  input  1  EX control: writes the register file.
- mem_to_reg  input  1  EX control: WB selects memory data.
- pc_branch  input  32  branch target from execute.
- alu_zero  input  1  ALU zero flag from execute.
- alu_res  input  32  ALU result / effective address.
- rt_data  input  32  store data.
- write_reg  input  5  destination register from execute.
- pcsrc  output  1  taken branch, to fetch.
- pc_branch_out  output  32  registered branch target, to fetch.
- read_data_wb  output  32  MEM/WB loaded word.
- alu_res_wb  output  32  MEM/WB ALU result.
- write_reg_wb  output  5  MEM/WB destination register.
- reg_write_wb  output  1  MEM/WB control.
- mem_to_reg_wb  output  1  MEM/WB control.
- misalign_err  output  1  sticky misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All EX/MEM and MEM/WB fields clear to 0, so every output is 0, including pcsrc and misalign_err.
  - Data memory contents are not reset.
- EX/MEM register, rising edge, priority flush > stall > load:
  - flush=1: control bits (branch, mem_read, mem_write, reg_write, mem_to_reg) load 0. Data fields are don't-care; implement them as 0.
  - stall=1 (no flush): hold all fields.
  - Otherwise: capture all inputs.
- Memory access, during the cycle the instruction is in EX/MEM:
  - Word index = exmem_alu_res[DMEM_ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the depth.
  - Read is combinational from the array.
  - Write is synchronous on the rising edge, only when exmem_mem_write=1 and stall=0. A stalled store therefore writes exactly once, on its non-stalled edge.
  - A load directly after a store to the same word returns the new data, because the write lands on the edge that moves the load into EX/MEM.
- Branch resolution (combinational from EX/MEM):
  - pcsrc = exmem_branch & exmem_zero.
  - pc_branch_out = exmem_pc_branch.
  - Branch is resolved in MEM. The hazard unit drives flush to squash younger instructions; this block does not self-flush.
- MEM/WB register, rising edge:
  - stall=1: hold.
  - Otherwise capture read_data (from the array, or 0 when exmem_mem_read=0), alu_res, write_reg, reg_write and mem_to_reg.
  - flush does not affect MEM/WB.
- Latency: inputs presented before edge N appear on pcsrc/pc_branch_out after edge N, and on the *_wb outputs after edge N+1.
- Reset mid-operation: in-flight instructions are lost and no further writes occur. A write completed before reset persists in memory.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Any EX/MEM access with mem_read|mem_write=1 and exmem_alu_res[1:0]!=0 suppresses the memory write.
  - A misaligned load forces read_data to 0.
  - misalign_err sets on that edge (when not stalled) and stays 1 until reset.
- Undefined:
  - Address bits [1:0] are ignored and the access proceeds to the truncated word.
  - misalign_err is tied to 0.

Test Plan:
- Reset: drive random inputs with rst_n=0 (asserted asynchronously mid-cycle) -> all outputs 0 immediately; after release, first *_wb values appear two edges after inputs are applied.
- Store/load: sw alu_res=0x8, rt_data=0xDEADBEEF, then lw alu_res=0x8 with mem_read=1, mem_to_reg=1, reg_write=1, write_reg=5 -> read_data_wb=0xDEADBEEF, write_reg_wb=5 two edges after the lw is presented; wrap check: lw at 0x408 (DMEM_ADDR_W=8) -> same data.
- Branch: branch=1, alu_zero=1, pc_branch=0x40 -> pcsrc=1, pc_branch_out=0x40 after one edge; alu_zero=0 -> pcsrc=0.
- Flush: sw alu_res=0x10, rt_data=0x1234 with flush=1 -> later lw 0x10 returns prior contents; reg_write_wb=0 for the flushed slot.
- Stall: hold stall=1 for 3 cycles with sw 0x20 data 0xA5A5A5A5 in EX/MEM -> all outputs constant, one write observed, and the lw 0x20 that follows returns 0xA5A5A5A5.
- Macro on: sw alu_res=0x6, rt_data=0xFFFFFFFF -> word 1 unchanged and misalign_err=1, remaining 1 through subsequent aligned accesses until rst_n=0.
